// File: rtl/retire_trace_unit_if.sv
// Trace record drain port: one record per accepted handshake.
interface retire_trace_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              tr_valid;
  logic              tr_ready;
  logic [1:0]        tr_kind;
  logic [REG_W-1:0]  tr_tag;
  logic [DATA_W-1:0] tr_addr;
  logic [DATA_W-1:0] tr_data;

  modport master (output tr_valid, tr_kind, tr_tag, tr_addr, tr_data, input tr_ready);
  modport slave  (input tr_valid, tr_kind, tr_tag, tr_addr, tr_data, output tr_ready);
endinterface

// File: rtl/retire_trace_unit.sv
// Retirement monitor: taps WB/MEM/hlt, keeps saturating statistics and buffers
// per-cycle trace records in a FIFO, then sequences an orderly halt drain.
module retire_trace_unit #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 wb_regwrite,
  input  logic [REG_W-1:0]     wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 mem_write,
  input  logic [DATA_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic                 hlt,
  retire_trace_unit_if.master  tr,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     inst_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] KIND_REG   = 2'b00;
  localparam logic [1:0] KIND_STORE = 2'b01;
  localparam logic [1:0] KIND_HALT  = 2'b10;

  typedef enum logic [1:0] {RUN, HALT_PEND, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [1:0]        kind;
    logic [REG_W-1:0]  tag;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  rec_t             fifoMem [DEPTH];
  logic [AW-1:0]    headPtr, tailPtr;
  logic [AW:0]      count;
  state_t           state, stateNext;
  logic [CNT_W-1:0] cycleCnt, instCnt, dropCnt, cycleNext;
  rec_t             pushRec [3];
  logic [1:0]       pushCnt, dropNum;
  logic [AW+1:0]    freeSlots, avail;
  logic             trValid, pop;
  rec_t             headRec;

  assign headRec   = fifoMem[headPtr];
  assign trValid   = (count != '0);
  assign pop       = trValid & tr.tr_ready;
  assign freeSlots = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
  assign cycleNext = satAdd(cycleCnt, 2'd1);

  // Empty FIFO forces the record fields to zero so stale storage never leaks out.
  assign tr.tr_valid = trValid;
  assign tr.tr_kind  = trValid ? headRec.kind : '0;
  assign tr.tr_tag   = trValid ? headRec.tag  : '0;
  assign tr.tr_addr  = trValid ? headRec.addr : '0;
  assign tr.tr_data  = trValid ? headRec.data : '0;

  assign cycle_cnt = cycleCnt;
  assign inst_cnt  = instCnt;
  assign drop_cnt  = dropCnt;
  assign done      = (state == DONE);

  always_comb begin
    stateNext = state;
    pushCnt   = '0;
    dropNum   = '0;
    avail     = freeSlots;
    for (int k = 0; k < 3; k++) pushRec[k] = '0;
    case (state)
      RUN: begin
        if (en) begin
          // Slots are granted in generation order, so STORE loses before REG.
          if (wb_regwrite) begin
            if (avail != '0) begin
              pushRec[pushCnt] = '{KIND_REG, wb_reg, {DATA_W{1'b0}}, wb_data};
              pushCnt = pushCnt + 2'd1;
              avail   = avail - (AW+2)'(1);
            end else begin
              dropNum = dropNum + 2'd1;
            end
          end
          if (mem_write) begin
            if (avail != '0) begin
              pushRec[pushCnt] = '{KIND_STORE, {REG_W{1'b0}}, mem_addr, mem_wdata};
              pushCnt = pushCnt + 2'd1;
              avail   = avail - (AW+2)'(1);
            end else begin
              dropNum = dropNum + 2'd1;
            end
          end
          if (hlt) begin
            if (avail != '0) begin
              pushRec[pushCnt] = '{KIND_HALT, {REG_W{1'b0}}, {DATA_W{1'b0}}, DATA_W'(cycleNext)};
              pushCnt   = pushCnt + 2'd1;
              stateNext = DRAIN;
            end else begin
              stateNext = HALT_PEND;
            end
          end
        end
      end
      HALT_PEND: begin
        if (avail != '0) begin
          pushRec[0] = '{KIND_HALT, {REG_W{1'b0}}, {DATA_W{1'b0}}, DATA_W'(cycleCnt)};
          pushCnt    = 2'd1;
          stateNext  = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && headRec.kind == KIND_HALT) stateNext = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      cycleCnt <= '0;
      instCnt  <= '0;
      dropCnt  <= '0;
    end else begin
      state   <= stateNext;
      headPtr <= headPtr + AW'(pop);
      tailPtr <= tailPtr + AW'(pushCnt);
      count   <= count + (AW+1)'(pushCnt) - (AW+1)'(pop);
      if (state == RUN && en) begin
        cycleCnt <= cycleNext;
        if (hlt || wb_regwrite || mem_write) instCnt <= satAdd(instCnt, 2'd1);
        dropCnt <= satAdd(dropCnt, dropNum);
      end
    end
  end

  // Record storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < pushCnt) fifoMem[tailPtr + AW'(k)] <= pushRec[k];
    end
  end
endmodule

// File: tb/tb_retire_trace_unit.sv
// Bench for retire_trace_unit: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_retire_trace_unit;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 6;
  localparam int DEPTH  = 8;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, wbRegwrite = 1'b0, memWrite = 1'b0, hlt = 1'b0;
  logic [REG_W-1:0]  wbReg = '0;
  logic [DATA_W-1:0] wbData = '0, memAddr = '0, memWdata = '0;
  logic [CNT_W-1:0]  cycleCnt, instCnt, dropCnt;
  logic done;
  bit   clkRun = 1'b1;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct {
    int kind;
    int tag;
    int addr;
    int data;
  } mrec_t;

  mrec_t  mq[$];
  longint mCyc, mInst, mDrop;
  bit     mHalted, mHaltQueued, mDone;

  retire_trace_unit_if #(.DATA_W(DATA_W), .REG_W(REG_W)) trBus();

  retire_trace_unit #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wb_regwrite(wbRegwrite), .wb_reg(wbReg), .wb_data(wbData),
    .mem_write(memWrite), .mem_addr(memAddr), .mem_wdata(memWdata),
    .hlt(hlt), .tr(trBus),
    .cycle_cnt(cycleCnt), .inst_cnt(instCnt), .drop_cnt(dropCnt), .done(done)
  );

  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic modelReset();
    mq.delete();
    mCyc = 0; mInst = 0; mDrop = 0;
    mHalted = 0; mHaltQueued = 0; mDone = 0;
  endtask

  // One clock of behaviour, computed from the current inputs.
  task automatic modelStep();
    int    free;
    int    lost;
    bit    popNow;
    mrec_t r;
    popNow = (mq.size() > 0) && trBus.tr_ready;
    free   = DEPTH - mq.size() + (popNow ? 1 : 0);
    if (popNow) begin
      r = mq.pop_front();
      if (r.kind == 2) mDone = 1;
    end
    if (!mHalted) begin
      if (en) begin
        mCyc = sat(mCyc + 1);
        if (hlt || wbRegwrite || memWrite) mInst = sat(mInst + 1);
        lost = 0;
        if (wbRegwrite) begin
          if (free > 0) begin mq.push_back('{0, int'(wbReg), 0, int'(wbData)}); free--; end
          else lost++;
        end
        if (memWrite) begin
          if (free > 0) begin mq.push_back('{1, 0, int'(memAddr), int'(memWdata)}); free--; end
          else lost++;
        end
        mDrop = sat(mDrop + lost);
        if (hlt) begin
          mHalted = 1;
          if (free > 0) begin
            mq.push_back('{2, 0, 0, int'(mCyc & 64'hFFFF)});
            mHaltQueued = 1;
          end
        end
      end
    end else if (!mHaltQueued && free > 0) begin
      mq.push_back('{2, 0, 0, int'(mCyc & 64'hFFFF)});
      mHaltQueued = 1;
    end
  endtask

  task automatic compareAll();
    checkEq("tr_valid", trBus.tr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      checkEq("tr_kind", trBus.tr_kind, 64'(mq[0].kind));
      checkEq("tr_tag",  trBus.tr_tag,  64'(mq[0].tag));
      checkEq("tr_addr", trBus.tr_addr, 64'(mq[0].addr));
      checkEq("tr_data", trBus.tr_data, 64'(mq[0].data));
    end else begin
      checkEq("tr_kind_empty", trBus.tr_kind, 0);
      checkEq("tr_tag_empty",  trBus.tr_tag,  0);
      checkEq("tr_addr_empty", trBus.tr_addr, 0);
      checkEq("tr_data_empty", trBus.tr_data, 0);
    end
    checkEq("cycle_cnt", cycleCnt, mCyc);
    checkEq("inst_cnt",  instCnt,  mInst);
    checkEq("drop_cnt",  dropCnt,  mDrop);
    checkEq("done",      done,     mDone);
  endtask

  task automatic tick();
    if (trBus.tr_valid && trBus.tr_ready) pops++;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic setIdle(input logic enV, input logic rdyV);
    en = enV; trBus.tr_ready = rdyV;
    wbRegwrite = 0; memWrite = 0; hlt = 0;
  endtask

  task automatic setDual();
    wbRegwrite = 1; memWrite = 1;
    wbReg = REG_W'($urandom); wbData = DATA_W'($urandom);
    memAddr = DATA_W'($urandom); memWdata = DATA_W'($urandom);
  endtask

  task automatic randInputs(input bit allowHlt);
    en         = ($urandom_range(0, 7) != 0);
    wbRegwrite = $urandom_range(0, 1);
    memWrite   = $urandom_range(0, 2) == 0;
    wbReg      = REG_W'($urandom);
    wbData     = DATA_W'($urandom);
    memAddr    = DATA_W'($urandom);
    memWdata   = DATA_W'($urandom);
    hlt        = allowHlt && ($urandom_range(0, 39) == 0);
    trBus.tr_ready = $urandom_range(0, 1);
  endtask

  initial begin
    trBus.tr_ready = 1'b0;
    modelReset();
    #3;
    doReset();

    // Three REG retirements streamed straight through.
    setIdle(1, 1);
    wbRegwrite = 1; wbReg = 4'd5; wbData = 16'h1234;
    repeat (3) tick();
    checkEq("t1_cycle", cycleCnt, 3);
    checkEq("t1_inst", instCnt, 3);
    checkEq("t1_drop", dropCnt, 0);
    checkEq("t1_tag", trBus.tr_tag, 5);
    checkEq("t1_data", trBus.tr_data, 16'h1234);

    // REG and STORE in one cycle: REG first, single instruction.
    doReset();
    setIdle(1, 0);
    wbRegwrite = 1; wbReg = 4'd2; wbData = 16'h00AA;
    memWrite = 1; memAddr = 16'h0010; memWdata = 16'h00BB;
    tick();
    checkEq("t2_inst", instCnt, 1);
    checkEq("t2_kind0", trBus.tr_kind, 0);
    checkEq("t2_data0", trBus.tr_data, 16'h00AA);
    setIdle(0, 1);
    tick();
    checkEq("t2_kind1", trBus.tr_kind, 1);
    checkEq("t2_addr1", trBus.tr_addr, 16'h0010);
    checkEq("t2_data1", trBus.tr_data, 16'h00BB);

    // Fill, overflow, same-cycle pop, then halt with a full FIFO.
    doReset();
    setIdle(1, 0);
    repeat (5) begin setDual(); tick(); end
    checkEq("t3_drop5", dropCnt, 2);
    trBus.tr_ready = 1; setDual(); tick();
    checkEq("t3_drop6", dropCnt, 3);
    setIdle(1, 0); hlt = 1; tick();
    repeat (4) begin setDual(); en = 1; hlt = $urandom_range(0, 1); tick(); end
    checkEq("t3_drop_frozen", dropCnt, 3);
    checkEq("t3_cycle_frozen", cycleCnt, 7);
    setIdle(1, 1); pops = 0;
    for (int i = 0; i < 40 && !done; i++) tick();
    checkEq("t3_pops", pops, 9);
    checkEq("t3_done", done, 1);
    checkEq("t3_valid", trBus.tr_valid, 0);

    // Asynchronous reset while draining, with the clock held.
    doReset();
    setIdle(1, 0);
    repeat (3) begin setDual(); tick(); end
    setIdle(1, 0); hlt = 1; tick();
    setIdle(1, 1);
    repeat (2) tick();
    clkRun = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkEq("t4_valid", trBus.tr_valid, 0);
    checkEq("t4_done", done, 0);
    checkEq("t4_cycle", cycleCnt, 0);
    checkEq("t4_inst", instCnt, 0);
    checkEq("t4_drop", dropCnt, 0);
    modelReset();
    #10;
    clkRun = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized episodes; long enough for the counters to saturate.
    for (int ep = 0; ep < 3; ep++) begin
      doReset();
      for (int c = 0; c < 250 && !done; c++) begin
        randInputs(c > 80);
        tick();
      end
      setIdle(1, 1); hlt = 1;
      for (int i = 0; i < 40 && !done; i++) tick();
      checkEq("rand_done", done, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
